// File: rtl/clock_defs.sv
// Constants and BCD step helper shared by the second/minute/hour stages of the clock chain.
package clock_defs;

    localparam int MIN1_MAX         = 9;
    localparam int MIN10_MAX        = 5;
    localparam int HOUR1_MAX        = 9;
    localparam int HOUR_WRAP_10     = 2;
    localparam int HOUR_WRAP_1      = 3;
    localparam int DEBOUNCE_DEFAULT = 250000;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    typedef struct packed {
        logic  wrap;
        bcd2_t val;
    } min_step_t;

    // >= compares let an out-of-range value fall back into 00..59.
    function automatic min_step_t min_step(input bcd2_t cur);
        min_step_t r;
        r      = '0;
        r.val  = cur;
        if (cur.ones >= 4'(MIN1_MAX)) begin
            r.val.ones = 4'd0;
            if (cur.tens >= 4'(MIN10_MAX)) begin
                r.val.tens = 4'd0;
                r.wrap     = 1'b1;
            end else begin
                r.val.tens = cur.tens + 4'd1;
            end
        end else begin
            r.val.ones = cur.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchronizer, stable-count debounce and a
// registered one-cycle pulse on each debounced press.
module btn_debounce
    import clock_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic          ok1, ok2;
    logic          armed;
    logic          db, db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            ok1       <= 1'b0;
            ok2       <= 1'b0;
            armed     <= 1'b0;
            db        <= 1'b0;
            db_q      <= 1'b0;
            cnt       <= '0;
            btn_pulse <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            // ok2 marks sync2 as a real sample rather than the reset value;
            // a press only counts once the button has been seen released,
            // so a button held across reset cannot fire.
            ok1   <= 1'b1;
            ok2   <= ok1;
            if (ok2 && !sync2)
                armed <= 1'b1;

            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            db_q      <= db;
            btn_pulse <= db & ~db_q & armed;
        end
    end

endmodule

// File: rtl/minute.sv
// BCD minute counter: advances on the seconds-stage tick or the debounced
// minute-set button; only tick-driven 59->00 wraps carry into the hour stage.
module minute
    import clock_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       w_m,
    input  logic       mplus,
    output logic       w_h,
    output logic [3:0] min_10,
    output logic [3:0] min1
);

    logic      inc_req;
    logic      pending;
    bcd2_t     cnt;
    min_step_t nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mplus (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (mplus),
        .btn_pulse(inc_req)
    );

    assign nxt = min_step(cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            pending <= 1'b0;
            w_h     <= 1'b0;
        end else begin
            w_h <= 1'b0;
            if (w_m) begin
                // Tick has priority; a colliding manual step waits in pending.
                cnt <= nxt.val;
                w_h <= nxt.wrap;
                if (inc_req)
                    pending <= 1'b1;
            end else if (inc_req || pending) begin
                cnt     <= nxt.val;
                pending <= pending & inc_req;
            end
        end
    end

    assign min_10 = cnt.tens;
    assign min1   = cnt.ones;

endmodule
